// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the display channel scheduler: channel geometry,
// CPU handshake states and the next-enabled-channel search.
package disp_sched_pkg;

    localparam int CH_W = 3;
    localparam int N_CH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACK
    } cpu_state_e;

    // Searches upward from cur+1, wrapping 7->0; cur itself is checked last so a
    // lone enabled channel maps to itself. An empty mask falls back to channel 0.
    function automatic logic [CH_W-1:0] next_enabled_ch(
        input logic [CH_W-1:0] cur,
        input logic [N_CH-1:0] mask
    );
        logic [CH_W-1:0] idx;
        logic [CH_W-1:0] res;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = cur + CH_W'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_dwell_timer.sv
// Dwell counter for auto-scan: counts 0..DWELL_CYCLES-1 while run is high and
// flags expire on the terminal count; clear forces it back to 0.
module disp_dwell_timer #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_ch_sched.sv
// Display channel scheduler: manual/auto-scan channel select plus CPU write handshake.
// Optional feature macro DISP_CPU_FOCUS_EN: a CPU write in auto mode jumps to channel 0 for a full dwell.
module disp_ch_sched
    import disp_sched_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            auto_en,
    input  logic [CH_W-1:0] sw_ch,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            cpu_req,
    output logic            cpu_ack,
    output logic            en,
    output logic [CH_W-1:0] test,
    output logic            scan_tick
);

    cpu_state_e      state_q, state_d;
    logic [CH_W-1:0] test_q, test_d;
    logic            tick_q, tick_d;
    logic            en_q, en_d;
    logic            ack_q, ack_d;
    logic            focus_load;
    logic            timer_clear;
    logic            expire;

`ifdef DISP_CPU_FOCUS_EN
    assign focus_load = auto_en && (state_q == LOAD);
`else
    assign focus_load = 1'b0;
`endif

    // Manual mode parks the counter at 0 so a later switch to auto starts a fresh dwell.
    assign timer_clear = !auto_en || focus_load;

    disp_dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .CNT_W       (CNT_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .run   (auto_en),
        .expire(expire)
    );

    always_comb begin
        test_d = test_q;
        tick_d = 1'b0;
        if (!auto_en) begin
            test_d = sw_ch;
        end else if (focus_load) begin
            test_d = '0;
        end else if (expire) begin
            test_d = next_enabled_ch(test_q, ch_mask);
            tick_d = |ch_mask;
        end
    end

    // en/cpu_ack are decoded from the next state so they are registered yet line up with it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req) state_d = LOAD;
            LOAD:    state_d = ACK;
            ACK:     if (!cpu_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        en_d  = (state_d == LOAD);
        ack_d = (state_d == ACK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            test_q  <= '0;
            tick_q  <= 1'b0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            test_q  <= test_d;
            tick_q  <= tick_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    assign test      = test_q;
    assign scan_tick = tick_q;
    assign en        = en_q;
    assign cpu_ack   = ack_q;

endmodule

// File: tb/tb_disp_ch_sched.sv
// Directed bench for disp_ch_sched with a 4-cycle dwell; expected values are hand-derived.
module tb_disp_ch_sched;

    logic       clk;
    logic       rst;
    logic       auto_en;
    logic [2:0] sw_ch;
    logic [7:0] ch_mask;
    logic       cpu_req;
    logic       cpu_ack;
    logic       en;
    logic [2:0] test;
    logic       scan_tick;

    int test_count = 0;
    int fail_count = 0;

    disp_ch_sched #(
        .DWELL_CYCLES(4),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .auto_en  (auto_en),
        .sw_ch    (sw_ch),
        .ch_mask  (ch_mask),
        .cpu_req  (cpu_req),
        .cpu_ack  (cpu_ack),
        .en       (en),
        .test     (test),
        .scan_tick(scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic a_en, input logic [2:0] ch, input logic [7:0] mask, input logic req);
        auto_en = a_en;
        sw_ch   = ch;
        ch_mask = mask;
        cpu_req = req;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_test", 32'(test), 0);
        checkOutput("rst_en", 32'(en), 0);
        checkOutput("rst_ack", 32'(cpu_ack), 0);
        checkOutput("rst_tick", 32'(scan_tick), 0);
        stepCycles(2);
        checkOutput("rst_hold_test", 32'(test), 0);
        rst = 1'b1;

        // Full mask: advance every 4 cycles through all eight channels.
        for (int ch = 1; ch <= 8; ch++) begin
            stepCycles(3);
            checkOutput("ff_dwell_test", 32'(test), 32'((ch - 1) % 8));
            checkOutput("ff_dwell_tick", 32'(scan_tick), 0);
            stepCycles(1);
            checkOutput("ff_adv_test", 32'(test), 32'(ch % 8));
            checkOutput("ff_adv_tick", 32'(scan_tick), 1);
        end

        // Sparse mask 1010_0100 from channel 0.
        applyStimulus(1'b1, 3'd0, 8'b1010_0100, 1'b0);
        stepCycles(4);
        checkOutput("sparse_a", 32'(test), 2);
        checkOutput("sparse_a_tick", 32'(scan_tick), 1);
        stepCycles(4);
        checkOutput("sparse_b", 32'(test), 5);
        stepCycles(4);
        checkOutput("sparse_c", 32'(test), 7);
        stepCycles(4);
        checkOutput("sparse_wrap", 32'(test), 2);
        checkOutput("sparse_wrap_tick", 32'(scan_tick), 1);

        // Empty mask: drop to channel 0, never tick.
        applyStimulus(1'b1, 3'd0, 8'h00, 1'b0);
        stepCycles(3);
        checkOutput("zero_pre_test", 32'(test), 2);
        stepCycles(1);
        checkOutput("zero_test", 32'(test), 0);
        checkOutput("zero_tick", 32'(scan_tick), 0);
        for (int i = 0; i < 8; i++) begin
            stepCycles(1);
            checkOutput("zero_hold_tick", 32'(scan_tick), 0);
            checkOutput("zero_hold_test", 32'(test), 0);
        end

        // Only current channel enabled: stays put but still ticks.
        applyStimulus(1'b1, 3'd0, 8'h01, 1'b0);
        stepCycles(3);
        checkOutput("solo_pre_tick", 32'(scan_tick), 0);
        stepCycles(1);
        checkOutput("solo_test", 32'(test), 0);
        checkOutput("solo_tick", 32'(scan_tick), 1);

        // Manual mode with 1-cycle latency, then back to auto.
        applyStimulus(1'b0, 3'd6, 8'hFF, 1'b0);
        stepCycles(1);
        checkOutput("man_6", 32'(test), 6);
        applyStimulus(1'b0, 3'd3, 8'hFF, 1'b0);
        stepCycles(1);
        checkOutput("man_3", 32'(test), 3);
        applyStimulus(1'b0, 3'd6, 8'hFF, 1'b0);
        stepCycles(1);
        checkOutput("man_6b", 32'(test), 6);
        stepCycles(5);
        checkOutput("man_hold", 32'(test), 6);
        checkOutput("man_tick", 32'(scan_tick), 0);
        applyStimulus(1'b1, 3'd6, 8'hFF, 1'b0);
        stepCycles(3);
        checkOutput("m2a_dwell", 32'(test), 6);
        stepCycles(1);
        checkOutput("m2a_adv", 32'(test), 7);
        checkOutput("m2a_tick", 32'(scan_tick), 1);

        // CPU handshake in manual mode.
        applyStimulus(1'b0, 3'd6, 8'hFF, 1'b1);
        stepCycles(1);
        checkOutput("hs_en", 32'(en), 1);
        checkOutput("hs_en_ack", 32'(cpu_ack), 0);
        stepCycles(1);
        checkOutput("hs_en_drop", 32'(en), 0);
        checkOutput("hs_ack", 32'(cpu_ack), 1);
        for (int i = 0; i < 3; i++) begin
            stepCycles(1);
            checkOutput("hs_hold_en", 32'(en), 0);
            checkOutput("hs_hold_ack", 32'(cpu_ack), 1);
        end
        cpu_req = 1'b0;
        stepCycles(1);
        checkOutput("hs_release_ack", 32'(cpu_ack), 0);
        checkOutput("hs_release_en", 32'(en), 0);
        cpu_req = 1'b1;
        stepCycles(1);
        checkOutput("hs2_en", 32'(en), 1);
        stepCycles(1);
        checkOutput("hs2_ack", 32'(cpu_ack), 1);

        // Reset during ACK aborts immediately; held request restarts after release.
        rst = 1'b0;
        #1;
        checkOutput("rstack_ack", 32'(cpu_ack), 0);
        checkOutput("rstack_test", 32'(test), 0);
        checkOutput("rstack_en", 32'(en), 0);
        stepCycles(1);
        checkOutput("rstack_hold_en", 32'(en), 0);
        rst = 1'b1;
        stepCycles(1);
        checkOutput("rel_en", 32'(en), 1);
        stepCycles(1);
        checkOutput("rel_en_drop", 32'(en), 0);
        checkOutput("rel_ack", 32'(cpu_ack), 1);
        for (int i = 0; i < 3; i++) begin
            stepCycles(1);
            checkOutput("rel_no_en", 32'(en), 0);
        end
        cpu_req = 1'b0;
        stepCycles(1);
        checkOutput("rel_ack_drop", 32'(cpu_ack), 0);

        // CPU write during an auto-mode dwell on channel 5.
        applyStimulus(1'b0, 3'd5, 8'hFF, 1'b0);
        stepCycles(1);
        checkOutput("cpu5_man", 32'(test), 5);
        applyStimulus(1'b1, 3'd5, 8'hFF, 1'b0);
        stepCycles(1);
        cpu_req = 1'b1;
        stepCycles(1);
        checkOutput("cpu5_en", 32'(en), 1);
        checkOutput("cpu5_en_test", 32'(test), 5);
        stepCycles(1);
`ifdef DISP_CPU_FOCUS_EN
        checkOutput("focus_jump", 32'(test), 0);
        checkOutput("focus_no_tick", 32'(scan_tick), 0);
        for (int i = 0; i < 3; i++) begin
            stepCycles(1);
            checkOutput("focus_hold", 32'(test), 0);
        end
        stepCycles(1);
        checkOutput("focus_adv", 32'(test), 1);
        checkOutput("focus_adv_tick", 32'(scan_tick), 1);
`else
        checkOutput("nofocus_stay", 32'(test), 5);
        checkOutput("nofocus_ack", 32'(cpu_ack), 1);
        stepCycles(1);
        checkOutput("nofocus_adv", 32'(test), 6);
        checkOutput("nofocus_adv_tick", 32'(scan_tick), 1);
`endif
        cpu_req = 1'b0;
        stepCycles(1);
        checkOutput("final_ack_drop", 32'(cpu_ack), 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
